// File: rtl/decode_exec_pipe.sv
// D->X pipeline register of the 3-stage RV32I core: load-use hazard detection,
// WB->D forward selects, flush/hold handling and a saturating bubble counter.
module decode_exec_pipe #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_valid,
  input  logic [31:0] d_inst,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_rs1,
  input  logic [31:0] d_rs2,
  input  logic        wb_regwen,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  input  logic        hold,
  output logic        wb2d_a,
  output logic        wb2d_b,
  output logic        stall_d,
  output logic        x_valid,
  output logic [31:0] x_inst,
  output logic [31:0] x_pc,
  output logic [31:0] x_rs1,
  output logic [31:0] x_rs2,
  output logic [31:0] bubble_cnt
);

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_REG    = 7'b0110011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011
  } opcode_e;

  logic [6:0] d_op;
  logic [4:0] d_rs1_idx;
  logic [4:0] d_rs2_idx;
  logic [4:0] x_rd;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       load_in_x;

  always_comb begin
    d_op      = d_inst[6:0];
    d_rs1_idx = d_inst[19:15];
    d_rs2_idx = d_inst[24:20];
    x_rd      = x_inst[11:7];
    uses_rs1  = !((d_op == OP_LUI) || (d_op == OP_AUIPC) || (d_op == OP_JAL));
    uses_rs2  = (d_op == OP_REG) || (d_op == OP_STORE) || (d_op == OP_BRANCH);
    // x0 destinations are never hazards nor forwarding sources
    load_in_x = x_valid && (x_inst[6:0] == OP_LOAD) && (x_rd != 5'd0);
    wb2d_a    = wb_regwen && (wb_rd != 5'd0) && (wb_rd == d_rs1_idx);
    wb2d_b    = wb_regwen && (wb_rd != 5'd0) && (wb_rd == d_rs2_idx);
    stall_d   = load_in_x && d_valid && !flush && !hold &&
                ((uses_rs1 && (x_rd == d_rs1_idx)) || (uses_rs2 && (x_rd == d_rs2_idx)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_valid    <= 1'b0;
      x_inst     <= NOP_INST;
      x_pc       <= PC_RESET;
      x_rs1      <= '0;
      x_rs2      <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      x_valid <= 1'b0;
      x_inst  <= NOP_INST;
      if (d_valid && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 32'd1;
    end else if (hold) begin
      x_valid <= x_valid;
    end else if (stall_d) begin
      x_valid <= 1'b0;
      x_inst  <= NOP_INST;
      if (bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + 32'd1;
    end else begin
      x_valid <= d_valid;
      x_inst  <= d_valid ? d_inst : NOP_INST;
      x_pc    <= d_pc;
      x_rs1   <= d_rs1;
      x_rs2   <= d_rs2;
    end
  end

endmodule

// File: tb/tb_decode_exec_pipe.sv
// Self-checking bench for decode_exec_pipe: directed scenarios plus randomized
// traffic against a behavioural model of the X slot and bubble counter.
module tb_decode_exec_pipe;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] LW_X5   = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD_DEP = 32'h0072_8333; // add  x6,x5,x7
  localparam logic [31:0] LUI_X5  = 32'h0002_82B7; // lui  x5,0x28 (bits 19:15 = 5)
  localparam logic [31:0] LW_X0   = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD_X0  = 32'h0000_00B3; // add  x1,x0,x0
  localparam logic [31:0] SUB_X3  = 32'h4031_8233; // sub  x4,x3,x3

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_valid, wb_regwen, flush, hold;
  logic [31:0] d_inst, d_pc, d_rs1, d_rs2;
  logic [4:0]  wb_rd;
  logic        wb2d_a, wb2d_b, stall_d, x_valid;
  logic [31:0] x_inst, x_pc, x_rs1, x_rs2, bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic        m_valid;
  logic [31:0] m_inst, m_pc, m_rs1, m_rs2;
  longint unsigned m_cnt;

  always #5 clk = ~clk;

  decode_exec_pipe #(.PC_RESET(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_inst(d_inst), .d_pc(d_pc),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .wb_regwen(wb_regwen), .wb_rd(wb_rd),
    .flush(flush), .hold(hold), .wb2d_a(wb2d_a), .wb2d_b(wb2d_b),
    .stall_d(stall_d), .x_valid(x_valid), .x_inst(x_inst), .x_pc(x_pc),
    .x_rs1(x_rs1), .x_rs2(x_rs2), .bubble_cnt(bubble_cnt)
  );

  function automatic bit reads_rs1(input logic [31:0] inst);
    case (inst[6:0])
      7'b0110111, 7'b0010111, 7'b1101111: return 1'b0;
      default:                            return 1'b1;
    endcase
  endfunction

  function automatic bit reads_rs2(input logic [31:0] inst);
    case (inst[6:0])
      7'b0110011, 7'b0100011, 7'b1100011: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic bit exp_fwd(input logic [4:0] src);
    return wb_regwen && wb_rd != 0 && wb_rd == src;
  endfunction

  function automatic bit exp_stall();
    logic [4:0] rd;
    rd = m_inst[11:7];
    if (!(m_valid && m_inst[6:0] == 7'b0000011 && rd != 0 && d_valid && !flush && !hold))
      return 1'b0;
    return (reads_rs1(d_inst) && rd == d_inst[19:15]) ||
           (reads_rs2(d_inst) && rd == d_inst[24:20]);
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0; m_inst = NOP; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_cnt = 0;
  endfunction

  function automatic void count_bubble();
    if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
  endfunction

  task automatic drive(input logic v, input logic [31:0] inst, input logic fl,
                       input logic hd, input logic wen, input logic [4:0] rd);
    d_valid = v; d_inst = inst; flush = fl; hold = hd; wb_regwen = wen; wb_rd = rd;
    d_pc = $urandom; d_rs1 = $urandom; d_rs2 = $urandom;
  endtask

  // Checks combinational outputs now, advances one edge, checks the X slot.
  task automatic cycle_check(input string tag);
    bit e_stall;
    #1;
    e_stall = exp_stall();
    n_tests++;
    if (wb2d_a !== exp_fwd(d_inst[19:15]) || wb2d_b !== exp_fwd(d_inst[24:20]) ||
        stall_d !== e_stall) begin
      n_fail++;
      $display("FAIL %s comb: a/b/stall=%b%b%b expected %b%b%b", tag, wb2d_a, wb2d_b,
               stall_d, exp_fwd(d_inst[19:15]), exp_fwd(d_inst[24:20]), e_stall);
    end
    if (flush) begin
      m_valid = 1'b0; m_inst = NOP;
      if (d_valid) count_bubble();
    end else if (hold) begin
    end else if (e_stall) begin
      m_valid = 1'b0; m_inst = NOP; count_bubble();
    end else begin
      m_valid = d_valid; m_inst = d_valid ? d_inst : NOP;
      m_pc = d_pc; m_rs1 = d_rs1; m_rs2 = d_rs2;
    end
    @(posedge clk); #1;
    n_tests++;
    if (x_valid !== m_valid || x_inst !== m_inst || x_pc !== m_pc || x_rs1 !== m_rs1 ||
        x_rs2 !== m_rs2 || bubble_cnt !== m_cnt[31:0]) begin
      n_fail++;
      $display("FAIL %s regs: v=%b inst=%h pc=%h rs1=%h rs2=%h cnt=%h expected v=%b inst=%h pc=%h rs1=%h rs2=%h cnt=%h",
               tag, x_valid, x_inst, x_pc, x_rs1, x_rs2, bubble_cnt,
               m_valid, m_inst, m_pc, m_rs1, m_rs2, m_cnt[31:0]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_tests++;
    if (x_valid !== 1'b0 || x_inst !== NOP || x_pc !== 32'h0 || x_rs1 !== 32'h0 ||
        x_rs2 !== 32'h0 || bubble_cnt !== 32'h0 || stall_d !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: v=%b inst=%h pc=%h rs1=%h rs2=%h cnt=%h stall=%b expected reset values",
               tag, x_valid, x_inst, x_pc, x_rs1, x_rs2, bubble_cnt, stall_d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, NOP, 1'b0, 1'b0, 1'b0, 5'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_values("reset_initial");
    rst_n = 1'b1;
    drive(1'b1, LW_X5, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle_check("reset_fill");
    // load-use pending in X with valid slot; reset mid-cycle clears it at once
    drive(1'b1, ADD_DEP, 1'b0, 1'b0, 1'b0, 5'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset_midrun");
    @(posedge clk); #2 rst_n = 1'b1;
    model_reset();
    drive(1'b1, ADD_DEP, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle_check("reset_release");
  endtask

  task automatic test_load_use();
    drive(1'b1, LW_X5, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle_check("lu_load");
    drive(1'b1, ADD_DEP, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle_check("lu_stall");
    drive(1'b1, ADD_DEP, 1'b0, 1'b0, 1'b1, 5'd5);
    cycle_check("lu_forward");
  endtask

  task automatic test_no_hazard();
    drive(1'b1, LW_X5, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle_check("nh_load");
    drive(1'b1, LUI_X5, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle_check("nh_lui");
    drive(1'b1, LW_X0, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle_check("nh_load_x0");
    drive(1'b1, ADD_X0, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle_check("nh_add_x0");
  endtask

  task automatic test_forward();
    drive(1'b1, SUB_X3, 1'b0, 1'b0, 1'b1, 5'd3);
    cycle_check("fwd_both");
    drive(1'b1, SUB_X3, 1'b0, 1'b0, 1'b1, 5'd0);
    cycle_check("fwd_rd0");
    drive(1'b0, SUB_X3, 1'b1, 1'b1, 1'b1, 5'd3);
    cycle_check("fwd_indep_ctl");
  endtask

  task automatic test_flush_hold();
    drive(1'b1, LW_X5, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle_check("fh_load");
    drive(1'b1, ADD_DEP, 1'b1, 1'b1, 1'b0, 5'd0);
    cycle_check("fh_flush_hold");
    drive(1'b1, LW_X5, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle_check("fh_reload");
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, ADD_DEP, 1'b0, 1'b1, 1'b0, 5'd0);
      cycle_check("fh_hold");
    end
    drive(1'b0, ADD_DEP, 1'b1, 1'b0, 1'b0, 5'd0);
    cycle_check("fh_flush_invalid");
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut.bubble_cnt = 32'hFFFF_FFFE;
    #1 release dut.bubble_cnt;
    m_cnt = 64'hFFFF_FFFE;
    @(posedge clk); #1;
    for (int unsigned i = 0; i < 2; i++) begin
      drive(1'b1, LW_X5, 1'b0, 1'b0, 1'b0, 5'd0);
      cycle_check("sat_load");
      drive(1'b1, ADD_DEP, 1'b0, 1'b0, 1'b0, 5'd0);
      cycle_check("sat_stall");
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [7];
    logic [31:0] inst;
    pool = '{32'h0000_0003, 32'h0000_0033, 32'h0000_0023, 32'h0000_0063,
             32'h0000_0037, 32'h0000_0013, 32'h0000_006F};
    for (int unsigned i = 0; i < 400; i++) begin
      inst = pool[$urandom_range(6)];
      inst[11:7]  = 5'($urandom_range(3));
      inst[19:15] = 5'($urandom_range(3));
      inst[24:20] = 5'($urandom_range(3));
      drive($urandom_range(9) != 0, inst, $urandom_range(9) == 0, $urandom_range(6) == 0,
            1'($urandom), 5'($urandom_range(3)));
      cycle_check("random");
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_forward();
    test_flush_hold();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
